imem_access_arbiter: RTL and testbench

Sequencer and arbiter for the byte-wide instruction memory (128 x 8, little-endian words: byte at addr is LSB). It shares the single memory port between the core's instruction-fetch requester and the program-loader requester. Each 32-bit access is serialized into four byte cycles, with round-robin arbitration when both requesters are pending. It sits between the core/loader and the memory array; the array has a 1-cycle synchronous read.

---
 rtl/imem_access_arbiter_if.sv | 50 +++++
 rtl/imem_access_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_imem_access_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
//  imem_access_arbiter_if
//  Fetch, load and byte-wide memory port bundle for the imem access arbiter.
//  Revision: 1.0
// ============================================================================
interface imem_access_arbiter_if #(
    parameter int ADDR_W = 7
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [31:0]       fetch_data;
    logic              fetch_err;

    logic              load_req;
    logic [31:0]       load_addr;
    logic [31:0]       load_data;
    logic              load_gnt;
    logic              load_done;
    logic              load_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    // Environment side: core fetch unit, program loader and memory array
    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_valid, fetch_data, fetch_err,
        output load_req, load_addr, load_data,
        input  load_gnt, load_done, load_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    // Arbiter side
    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_valid, fetch_data, fetch_err,
        input  load_req, load_addr, load_data,
        output load_gnt, load_done, load_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  imem_access_arbiter
//  Round-robin fetch/load arbiter serializing 32-bit words onto a byte memory.
//  Option: IMEM_LOAD_LOCK_EN rejects loads after the first good fetch.
//  Revision: 1.0
// ============================================================================
module imem_access_arbiter #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  wire logic             clk,
    input  wire logic             reset,
    imem_access_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_LAST = 3'd2,
        WR      = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam logic [31:0] c_last_word   = 32'(DEPTH - 4);
    localparam logic        c_grant_fetch = 1'b0;
    localparam logic        c_grant_load  = 1'b1;

    state_t            state_q,       state_d;
    logic [1:0]        cnt_q,         cnt_d;
    logic              last_grant_q,  last_grant_d;
    logic              owner_q,       owner_d;
    logic [ADDR_W-1:0] base_q,        base_d;
    logic [31:0]       wdata_q,       wdata_d;
    logic [31:0]       fetch_data_q,  fetch_data_d;
    logic              fetch_gnt_q,   fetch_gnt_d;
    logic              load_gnt_q,    load_gnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_err_q,   fetch_err_d;
    logic              load_done_q,   load_done_d;
    logic              load_err_q,    load_err_d;

    logic              w_pick_load;
    logic [31:0]       w_sel_addr;
    logic              w_addr_ok;
    logic [1:0]        w_cap_idx;
    logic              w_load_locked;

    // Load wins when it is alone, or on contention when fetch had the last grant
    assign w_pick_load = bus.load_req && (!bus.fetch_req || (last_grant_q == c_grant_fetch));
    assign w_sel_addr  = w_pick_load ? bus.load_addr : bus.fetch_addr;
    assign w_addr_ok   = (w_sel_addr[1:0] == 2'b00) && (w_sel_addr <= c_last_word);

    // Read data lags the address by one cycle, so the byte landing now is cnt-1
    // (in RD_LAST the counter has wrapped to 0, giving index 3)
    assign w_cap_idx = cnt_q - 2'd1;

`ifdef IMEM_LOAD_LOCK_EN
    logic lock_q, lock_d;

    assign w_load_locked = lock_q;

    always_comb begin
        lock_d = lock_q | (fetch_valid_d & ~fetch_err_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    assign w_load_locked = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        fetch_data_d  = fetch_data_q;
        fetch_gnt_d   = 1'b0;
        load_gnt_d    = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_err_d   = 1'b0;
        load_done_d   = 1'b0;
        load_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.fetch_req || bus.load_req) begin
                    owner_d      = w_pick_load;
                    last_grant_d = w_pick_load;
                    fetch_gnt_d  = ~w_pick_load;
                    load_gnt_d   = w_pick_load;
                    base_d       = w_sel_addr[ADDR_W-1:0];
                    wdata_d      = bus.load_data;
                    cnt_d        = 2'd0;
                    if (!w_addr_ok || (w_pick_load && w_load_locked)) begin
                        state_d = ERR;
                    end else if (w_pick_load) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end

            RD: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q != 2'd0) begin
                    fetch_data_d[{w_cap_idx, 3'b000} +: 8] = bus.mem_rdata;
                end
                if (cnt_q == 2'd3) begin
                    state_d = RD_LAST;
                end
            end

            RD_LAST: begin
                fetch_data_d[{w_cap_idx, 3'b000} +: 8] = bus.mem_rdata;
                fetch_valid_d = 1'b1;
                state_d       = IDLE;
            end

            WR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    load_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            ERR: begin
                if (owner_q == c_grant_load) begin
                    load_done_d = 1'b1;
                    load_err_d  = 1'b1;
                end else begin
                    fetch_valid_d = 1'b1;
                    fetch_err_d   = 1'b1;
                    fetch_data_d  = 32'd0;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            last_grant_q  <= c_grant_load;
            owner_q       <= c_grant_fetch;
            base_q        <= '0;
            wdata_q       <= 32'd0;
            fetch_data_q  <= 32'd0;
            fetch_gnt_q   <= 1'b0;
            load_gnt_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            load_done_q   <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            fetch_data_q  <= fetch_data_d;
            fetch_gnt_q   <= fetch_gnt_d;
            load_gnt_q    <= load_gnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            load_done_q   <= load_done_d;
            load_err_q    <= load_err_d;
        end
    end

    // Memory port is active only while a byte sequence is in flight
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = 8'd0;
        if (state_q == RD || state_q == WR) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = base_q + ADDR_W'(cnt_q);
            if (state_q == WR) begin
                bus.mem_we    = 1'b1;
                bus.mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
            end
        end
    end

    assign bus.fetch_gnt   = fetch_gnt_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.load_gnt    = load_gnt_q;
    assign bus.load_done   = load_done_q;
    assign bus.load_err    = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_imem_access_arbiter
//  Scoreboard bench: byte memory model, reference memory, logged DUT events.
//  Revision: 1.0
// ============================================================================
module tb_imem_access_arbiter;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
`ifdef IMEM_LOAD_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } ev_t;

    typedef struct {
        int              cyc;
        logic            we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]      wdata;
    } mop_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_access_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    imem_access_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous byte memory, 1-cycle read latency
    logic [7:0]        mem [DEPTH];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [7:0]        pre_data;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    logic [7:0] ref_mem [DEPTH];
    bit         exp_lock;
    int         cyc;
    int         checks;
    int         failures;

    int   fg_log[$];
    int   lg_log[$];
    ev_t  fv_log[$];
    ev_t  ld_log[$];
    mop_t mem_log[$];
    exp_t exp_fetch[$];
    exp_t exp_load[$];

    task automatic clear_logs();
        fg_log.delete(); lg_log.delete(); fv_log.delete();
        ld_log.delete(); mem_log.delete();
    endtask

    // One cycle: advance to the falling edge, log outputs, drop granted requests
    task automatic step();
        ev_t  ev;
        mop_t mo;
        @(negedge clk);
        cyc++;
        if (bus.fetch_gnt) begin fg_log.push_back(cyc); bus.fetch_req = 1'b0; end
        if (bus.load_gnt)  begin lg_log.push_back(cyc); bus.load_req  = 1'b0; end
        if (bus.fetch_valid) begin
            ev.cyc = cyc; ev.data = bus.fetch_data; ev.err = bus.fetch_err;
            fv_log.push_back(ev);
        end
        if (bus.load_done) begin
            ev.cyc = cyc; ev.data = 32'd0; ev.err = bus.load_err;
            ld_log.push_back(ev);
        end
        if (bus.mem_en) begin
            mo.cyc = cyc; mo.we = bus.mem_we; mo.addr = bus.mem_addr; mo.wdata = bus.mem_wdata;
            mem_log.push_back(mo);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'(DEPTH - 4));
    endfunction

    task automatic fetch_issue(input logic [31:0] a);
        exp_t e;
        int   b;
        b = int'(a[ADDR_W-1:0]);
        if (addr_valid(a)) begin
            e.data = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
            e.err  = 1'b0;
            exp_lock = 1'b1;
        end else begin
            e.data = 32'd0;
            e.err  = 1'b1;
        end
        exp_fetch.push_back(e);
        bus.fetch_addr = a;
        bus.fetch_req  = 1'b1;
    endtask

    task automatic load_issue(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   b;
        b = int'(a[ADDR_W-1:0]);
        e.data = d;
        e.err  = !addr_valid(a) || (LOCK && exp_lock);
        if (!e.err) for (int i = 0; i < 4; i++) ref_mem[b+i] = d[8*i +: 8];
        exp_load.push_back(e);
        bus.load_addr = a;
        bus.load_data = d;
        bus.load_req  = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.fetch_req = 1'b0; bus.fetch_addr = 32'd0;
        bus.load_req = 1'b0; bus.load_addr = 32'd0; bus.load_data = 32'd0;
        exp_lock = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
        ref_mem[0] = 8'hB3; ref_mem[1] = 8'h81; ref_mem[2] = 8'h20; ref_mem[3] = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            pre_we = 1'b1; pre_addr = ADDR_W'(i); pre_data = ref_mem[i];
            step();
        end
        pre_we = 1'b0;
        checks++;
        if ({bus.fetch_gnt, bus.fetch_valid, bus.fetch_err, bus.fetch_data,
             bus.load_gnt, bus.load_done, bus.load_err} !== 39'd0) begin
            failures++;
            $display("FAIL reset_handshake: got %h want 0", {bus.fetch_gnt, bus.fetch_valid,
                     bus.fetch_err, bus.fetch_data, bus.load_gnt, bus.load_done, bus.load_err});
        end
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 17'd0) begin
            failures++;
            $display("FAIL reset_mem_port: got %h want 0",
                     {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_read();
        int   t;
        exp_t e;
        clear_logs();
        t = cyc;
        fetch_issue(32'h0);
        repeat (8) step();
        checks++;
        if (fg_log.size() != 1 || fg_log[0] != t + 1) begin
            failures++;
            $display("FAIL read_gnt: got n=%0d first=%0d want cyc %0d", fg_log.size(),
                     (fg_log.size() > 0) ? fg_log[0] : -1, t + 1);
        end
        checks++;
        if (mem_log.size() != 4) begin
            failures++;
            $display("FAIL read_mem_count: got %0d want 4", mem_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mem_log[i].cyc != t + 1 + i || mem_log[i].we !== 1'b0 ||
                    mem_log[i].addr !== ADDR_W'(i)) begin
                    failures++;
                    $display("FAIL read_mem_op%0d: got cyc=%0d we=%b addr=%h want cyc=%0d we=0 addr=%h",
                             i, mem_log[i].cyc, mem_log[i].we, mem_log[i].addr, t + 1 + i, i);
                end
            end
        end
        e = exp_fetch.pop_front();
        checks++;
        if (fv_log.size() != 1 || fv_log[0].cyc != t + 6 ||
            fv_log[0].data !== e.data || fv_log[0].err !== e.err) begin
            failures++;
            $display("FAIL read_result: got n=%0d cyc=%0d data=%h err=%b want cyc=%0d data=%h err=%b",
                     fv_log.size(), (fv_log.size() > 0) ? fv_log[0].cyc : -1,
                     (fv_log.size() > 0) ? fv_log[0].data : 32'hx,
                     (fv_log.size() > 0) ? fv_log[0].err : 1'bx, t + 6, e.data, e.err);
        end
        checks++;
        if (e.data !== 32'h002081B3) begin
            failures++;
            $display("FAIL read_ref_word: got %h want 002081b3", e.data);
        end
    endtask

    task automatic test_write_read();
        int          t;
        exp_t        e;
        logic [31:0] d;
        clear_logs();
        t = cyc;
        d = 32'h4020A1B3;
        load_issue(32'h10, d);
        repeat (7) step();
        e = exp_load.pop_front();
        checks++;
        if (lg_log.size() != 1 || lg_log[0] != t + 1) begin
            failures++;
            $display("FAIL write_gnt: got n=%0d want cyc %0d", lg_log.size(), t + 1);
        end
        checks++;
        if (mem_log.size() != (e.err ? 0 : 4)) begin
            failures++;
            $display("FAIL write_mem_count: got %0d want %0d", mem_log.size(), e.err ? 0 : 4);
        end else if (!e.err) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mem_log[i].cyc != t + 1 + i || mem_log[i].we !== 1'b1 ||
                    mem_log[i].addr !== ADDR_W'(16 + i) || mem_log[i].wdata !== d[8*i +: 8]) begin
                    failures++;
                    $display("FAIL write_mem_op%0d: got cyc=%0d we=%b addr=%h wd=%h want cyc=%0d addr=%h wd=%h",
                             i, mem_log[i].cyc, mem_log[i].we, mem_log[i].addr, mem_log[i].wdata,
                             t + 1 + i, 16 + i, d[8*i +: 8]);
                end
            end
        end
        checks++;
        if (ld_log.size() != 1 || ld_log[0].cyc != t + (e.err ? 2 : 5) || ld_log[0].err !== e.err) begin
            failures++;
            $display("FAIL write_done: got n=%0d cyc=%0d want cyc=%0d err=%b", ld_log.size(),
                     (ld_log.size() > 0) ? ld_log[0].cyc : -1, t + (e.err ? 2 : 5), e.err);
        end
        clear_logs();
        t = cyc;
        fetch_issue(32'h10);
        repeat (8) step();
        e = exp_fetch.pop_front();
        checks++;
        if (fv_log.size() != 1 || fv_log[0].cyc != t + 6 ||
            fv_log[0].data !== e.data || fv_log[0].err !== 1'b0) begin
            failures++;
            $display("FAIL readback_0x10: got n=%0d data=%h want data=%h err=0", fv_log.size(),
                     (fv_log.size() > 0) ? fv_log[0].data : 32'hx, e.data);
        end
    endtask

    task automatic test_contention();
        int   t;
        exp_t ef, el;
        reset = 1'b1;
        step();
        exp_lock = 1'b0;
        clear_logs();
        fetch_issue(32'h0);
        load_issue(32'h20, 32'h11223344);
        reset = 1'b0;
        t = cyc;
        repeat (14) step();
        ef = exp_fetch.pop_front();
        el = exp_load.pop_front();
        checks++;
        if (fg_log.size() != 1 || fg_log[0] != t + 1) begin
            failures++;
            $display("FAIL contention_fetch_first: got n=%0d want cyc %0d", fg_log.size(), t + 1);
        end
        checks++;
        if (fv_log.size() != 1 || fv_log[0].cyc != t + 6 || fv_log[0].data !== ef.data) begin
            failures++;
            $display("FAIL contention_fetch_data: got n=%0d want cyc=%0d data=%h", fv_log.size(), t + 6, ef.data);
        end
        checks++;
        if (lg_log.size() != 1 || lg_log[0] != t + 7) begin
            failures++;
            $display("FAIL contention_load_gnt: got n=%0d first=%0d want cyc %0d", lg_log.size(),
                     (lg_log.size() > 0) ? lg_log[0] : -1, t + 7);
        end
        checks++;
        if (ld_log.size() != 1 || ld_log[0].cyc != t + 7 + (el.err ? 1 : 4) || ld_log[0].err !== el.err) begin
            failures++;
            $display("FAIL contention_load_done: got n=%0d want cyc=%0d err=%b", ld_log.size(),
                     t + 7 + (el.err ? 1 : 4), el.err);
        end
        // Last grant went to load, so fetch must win the next tie
        clear_logs();
        fetch_issue(32'h4);
        load_issue(32'h24, 32'h55667788);
        t = cyc;
        repeat (14) step();
        ef = exp_fetch.pop_front();
        el = exp_load.pop_front();
        checks++;
        if (fg_log.size() != 1 || lg_log.size() != 1 || fg_log[0] != t + 1 || lg_log[0] != t + 7) begin
            failures++;
            $display("FAIL contention_second_round: got fetch n=%0d load n=%0d want fetch %0d load %0d",
                     fg_log.size(), lg_log.size(), t + 1, t + 7);
        end
        checks++;
        if (fv_log.size() != 1 || fv_log[0].data !== ef.data || ld_log.size() != 1 || ld_log[0].err !== el.err) begin
            failures++;
            $display("FAIL contention_second_results: got fv=%0d ld=%0d want data=%h lerr=%b",
                     fv_log.size(), ld_log.size(), ef.data, el.err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [6] = '{32'h02, 32'h7C, 32'h7C, 32'h80, 32'hFFFF_FFFC, 32'h1000_0000};
        bit          is_ld [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        int   t;
        int   lat;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            clear_logs();
            t = cyc;
            if (is_ld[k]) load_issue(addrs[k], 32'hDEADBEEF);
            else          fetch_issue(addrs[k]);
            repeat (8) step();
            if (is_ld[k]) begin
                e = exp_load.pop_front();
                lat = e.err ? 2 : 5;
                checks++;
                if (ld_log.size() != 1 || ld_log[0].cyc != t + lat || ld_log[0].err !== e.err ||
                    mem_log.size() != (e.err ? 0 : 4)) begin
                    failures++;
                    $display("FAIL err_load_%0d addr=%h: got n=%0d mem=%0d want cyc=%0d err=%b", k, addrs[k],
                             ld_log.size(), mem_log.size(), t + lat, e.err);
                end
            end else begin
                e = exp_fetch.pop_front();
                lat = e.err ? 2 : 6;
                checks++;
                if (fv_log.size() != 1 || fv_log[0].cyc != t + lat || fv_log[0].err !== e.err ||
                    fv_log[0].data !== e.data || mem_log.size() != (e.err ? 0 : 4)) begin
                    failures++;
                    $display("FAIL err_fetch_%0d addr=%h: got n=%0d data=%h mem=%0d want cyc=%0d data=%h err=%b",
                             k, addrs[k], fv_log.size(), (fv_log.size() > 0) ? fv_log[0].data : 32'hx,
                             mem_log.size(), t + lat, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int   t;
        exp_t e;
        clear_logs();
        t = cyc;
        fetch_issue(32'h4);
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++;
        if ({bus.fetch_gnt, bus.fetch_valid, bus.fetch_err, bus.fetch_data, bus.load_gnt,
             bus.load_done, bus.load_err, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 56'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got mem_en=%b fetch_data=%h want all 0", bus.mem_en, bus.fetch_data);
        end
        reset = 1'b0;
        exp_lock = 1'b0;
        void'(exp_fetch.pop_front());
        repeat (6) step();
        checks++;
        if (fv_log.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_no_valid: got %0d pulses want 0", fv_log.size());
        end
        clear_logs();
        t = cyc;
        fetch_issue(32'h8);
        repeat (8) step();
        e = exp_fetch.pop_front();
        checks++;
        if (fv_log.size() != 1 || fv_log[0].cyc != t + 6 || fv_log[0].data !== e.data || fv_log[0].err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_recover: got n=%0d want cyc=%0d data=%h", fv_log.size(), t + 6, e.data);
        end
    endtask

    task automatic test_lock();
        int   t;
        exp_t e;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_lock = 1'b0;
        step();
        clear_logs();
        fetch_issue(32'h0);
        repeat (8) step();
        e = exp_fetch.pop_front();
        checks++;
        if (fv_log.size() != 1 || fv_log[0].data !== e.data || fv_log[0].err !== 1'b0) begin
            failures++;
            $display("FAIL lock_first_fetch: got n=%0d want data=%h", fv_log.size(), e.data);
        end
        clear_logs();
        t = cyc;
        load_issue(32'h20, 32'hA5A55A5A);
        repeat (7) step();
        e = exp_load.pop_front();
        checks++;
        if (e.err !== LOCK) begin
            failures++;
            $display("FAIL lock_model: got %b want %b", e.err, LOCK);
        end
        checks++;
        if (ld_log.size() != 1 || ld_log[0].cyc != t + (e.err ? 2 : 5) || ld_log[0].err !== e.err ||
            mem_log.size() != (e.err ? 0 : 4)) begin
            failures++;
            $display("FAIL lock_load: got n=%0d mem=%0d want cyc=%0d err=%b", ld_log.size(),
                     mem_log.size(), t + (e.err ? 2 : 5), e.err);
        end
        clear_logs();
        fetch_issue(32'h20);
        repeat (8) step();
        e = exp_fetch.pop_front();
        checks++;
        if (fv_log.size() != 1 || fv_log[0].data !== e.data) begin
            failures++;
            $display("FAIL lock_readback_0x20: got n=%0d data=%h want %h", fv_log.size(),
                     (fv_log.size() > 0) ? fv_log[0].data : 32'hx, e.data);
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        pre_we = 1'b0; pre_addr = '0; pre_data = 8'd0;
        test_reset();
        test_read();
        test_write_read();
        test_contention();
        test_errors();
        test_reset_mid();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
